// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the program counter and issues one instruction-memory
//            request at a time. Presents each fetched instruction to decode
//            with valid/stall flow control, and applies trap and
//            branch/jump redirects with trap taking priority.
// Ports    : clk, i_reset          clock, synchronous active-high reset
//            i_stall               decode cannot accept the held instruction
//            i_redirect_valid/pc   taken branch/jump target
//            i_trap_valid/pc       trap vector target (wins over redirect)
//            o_imem_req/addr       fetch request, held until i_imem_ack
//            i_imem_ack/data       fetch response (may arrive with the req)
//            o_inst_valid/inst/pc  instruction presented to decode
//            o_misaligned          1-cycle pulse, accepted target low bits != 0
// Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int                      DATA_WIDTH_P   = 32,
  parameter logic [DATA_WIDTH_P-1:0] RESET_VECTOR_P = '0
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_stall,
  input  logic                    i_redirect_valid,
  input  logic [DATA_WIDTH_P-1:0] i_redirect_pc,
  input  logic                    i_trap_valid,
  input  logic [DATA_WIDTH_P-1:0] i_trap_pc,
  output logic                    o_imem_req,
  output logic [DATA_WIDTH_P-1:0] o_imem_addr,
  input  logic                    i_imem_ack,
  input  logic [31:0]             i_imem_data,
  output logic                    o_inst_valid,
  output logic [31:0]             o_inst,
  output logic [DATA_WIDTH_P-1:0] o_inst_pc,
  output logic                    o_misaligned
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH_P-1:0] pc_q, pc_d;
  logic [DATA_WIDTH_P-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]             inst_q, inst_d;
  logic [DATA_WIDTH_P-1:0] inst_pc_q, inst_pc_d;
  logic                    inst_valid_q, inst_valid_d;
  logic                    misaligned_q, misaligned_d;

  logic                    redirect_any;
  logic [DATA_WIDTH_P-1:0] target_raw;
  logic [DATA_WIDTH_P-1:0] target;

  // Trap wins over a simultaneous branch/jump; targets are forced to word
  // alignment and the dropped low bits are reported via o_misaligned.
  assign redirect_any = i_trap_valid | i_redirect_valid;
  assign target_raw   = i_trap_valid ? i_trap_pc : i_redirect_pc;
  assign target       = {target_raw[DATA_WIDTH_P-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR_P;
      drain_addr_q <= RESET_VECTOR_P;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    misaligned_d = 1'b0;

    case (state_q)
      // Redirects are ignored here: nothing has been fetched yet.
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect_any) begin
          pc_d         = target;
          misaligned_d = |target_raw[1:0];
          // The in-flight request cannot be withdrawn; remember its address
          // so the bus sees a stable request until the stale ack returns.
          if (!i_imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (i_imem_ack) begin
          inst_d       = i_imem_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + DATA_WIDTH_P'(4);
          state_d      = S_FULL;
        end
      end

      S_FULL: begin
        // The held instruction is younger than any redirect seen now, so a
        // redirect flushes it even while decode is stalled.
        if (redirect_any) begin
          inst_valid_d = 1'b0;
          pc_d         = target;
          misaligned_d = |target_raw[1:0];
          state_d      = S_FETCH;
        end else if (!i_stall) begin
          inst_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (redirect_any) begin
          pc_d         = target;
          misaligned_d = |target_raw[1:0];
        end
        if (i_imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign o_imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign o_imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign o_inst_valid = inst_valid_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_misaligned = misaligned_q;

endmodule
`default_nettype wire
